// File: rtl/axis_pack_32to128_pkg.sv
// Shared definitions for the 32->128 AXI4-Stream packer: beat widths,
// lane index width, FSM state type and the keep popcount helper.
// Optional feature macro used by this slice: AXIS_PACK_BYTE_CNT_EN.
package axis_pack_32to128_pkg;

   localparam int IN_W_DEF       = 32;
   localparam int RATIO_DEF      = 4;
   localparam int OUT_W_DEF      = IN_W_DEF * RATIO_DEF;
   localparam int IN_KEEP_W_DEF  = IN_W_DEF / 8;
   localparam int OUT_KEEP_W_DEF = OUT_W_DEF / 8;
   localparam int BYTE_CNT_W     = 32;

   // Lane index width; a one-lane packer still gets a 1-bit index.
   function automatic int lane_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   localparam int LANE_W = lane_w(RATIO_DEF);

   // IDLE: lane 0 and accumulator empty. FILL: at least one lane written.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } pack_state_t;

   // Number of set bits in a keep vector (zero-extended to 32 bits).
   function automatic logic [BYTE_CNT_W-1:0] popcount(input logic [31:0] v);
      logic [BYTE_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + BYTE_CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_pack_32to128_if.sv
// AXI4-Stream bundle used on both sides of the packer.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both 1; once tvalid is raised, tdata/tkeep/tlast stay stable and
// tvalid stays high until that transfer happens.
interface axis_pack_32to128_if #(
   parameter int W = 32
);
   logic [W-1:0]   tdata;
   logic [W/8-1:0] tkeep;
   logic           tlast;
   logic           tvalid;
   logic           tready;

   modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pack_32to128_outreg.sv
// axis_pack_outreg: single-entry stream holding register. The payload is
// loaded whenever the producer asserts load (only legal while load_ready)
// and held stable until the consumer takes it.
module axis_pack_outreg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_payload,
   output logic         load_ready,
   output logic         out_valid,
   output logic [W-1:0] out_payload,
   input  logic         out_ready
);

   // Register can accept a new word when empty or draining this cycle.
   always_comb begin
      load_ready = ~out_valid | out_ready;
   end

   // Load has priority so a drain and a refill in one cycle leave no gap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_payload <= load_payload;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_pack_32to128.sv
// axis_pack_32to128: gathers IN_W-bit beats into IN_W*RATIO-bit words,
// little-endian lanes, tkeep carried per lane, tlast closes a word early.
// Define AXIS_PACK_BYTE_CNT_EN to add the pkt_bytes/last_pkt_bytes counters.
module axis_pack_32to128
   import axis_pack_32to128_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int RATIO = RATIO_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   axis_pack_32to128_if.slave    s_axis,
   axis_pack_32to128_if.master   m_axis,
   output pack_state_t           dbg_state
`ifdef AXIS_PACK_BYTE_CNT_EN
   ,
   output logic [BYTE_CNT_W-1:0] pkt_bytes,
   output logic [BYTE_CNT_W-1:0] last_pkt_bytes
`endif
);

   localparam int KW     = IN_W / 8;
   localparam int OUT_W  = IN_W * RATIO;
   localparam int OUT_KW = OUT_W / 8;
   localparam int LW     = lane_w(RATIO);
   localparam int PAY_W  = 1 + OUT_KW + OUT_W;

   pack_state_t       state, nxt_state;
   logic [LW-1:0]     lane, nxt_lane;
   logic [OUT_W-1:0]  acc_data, nxt_acc_data, merged_data;
   logic [OUT_KW-1:0] acc_keep, nxt_acc_keep, merged_keep;
   logic              resetn_q;
   logic              s_ready, accept, complete, load_ready;
   logic [PAY_W-1:0]  out_payload;

   // Hold input ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) resetn_q <= 1'b0;
      else         resetn_q <= 1'b1;
   end

   assign s_ready       = resetn_q & load_ready;
   assign s_axis.tready = s_ready;
   assign accept        = s_axis.tvalid & s_ready;
   assign dbg_state     = state;

   // Next-state: merge the accepted beat into its lane, flush on completion.
   always_comb begin
      nxt_state    = state;
      nxt_lane     = lane;
      nxt_acc_data = acc_data;
      nxt_acc_keep = acc_keep;
      complete     = 1'b0;
      merged_data  = acc_data;
      merged_keep  = acc_keep;
      merged_data[int'(lane)*IN_W +: IN_W] = s_axis.tdata;
      merged_keep[int'(lane)*KW +: KW]     = s_axis.tkeep;
      if (accept) begin
         if (lane == LW'(RATIO - 1) || s_axis.tlast) begin
            complete     = 1'b1;
            nxt_state    = ST_IDLE;
            nxt_lane     = '0;
            nxt_acc_data = '0;
            nxt_acc_keep = '0;
         end else begin
            nxt_state    = ST_FILL;
            nxt_lane     = lane + LW'(1);
            nxt_acc_data = merged_data;
            nxt_acc_keep = merged_keep;
         end
      end
   end

   // State, lane index and accumulator registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         lane     <= '0;
         acc_data <= '0;
         acc_keep <= '0;
      end else begin
         state    <= nxt_state;
         lane     <= nxt_lane;
         acc_data <= nxt_acc_data;
         acc_keep <= nxt_acc_keep;
      end
   end

   axis_pack_outreg #(.W(PAY_W)) u_outreg (
      .clk          (clk),
      .resetn       (resetn),
      .load         (complete),
      .load_payload ({s_axis.tlast, merged_keep, merged_data}),
      .load_ready   (load_ready),
      .out_valid    (m_axis.tvalid),
      .out_payload  (out_payload),
      .out_ready    (m_axis.tready)
   );

   assign m_axis.tdata = out_payload[OUT_W-1:0];
   assign m_axis.tkeep = out_payload[OUT_W +: OUT_KW];
   assign m_axis.tlast = out_payload[PAY_W-1];

`ifdef AXIS_PACK_BYTE_CNT_EN
   logic [BYTE_CNT_W-1:0] beat_bytes;
   assign beat_bytes = popcount(32'(s_axis.tkeep));

   // Running byte count per packet, latched and restarted on tlast.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_bytes      <= '0;
         last_pkt_bytes <= '0;
      end else if (accept) begin
         if (s_axis.tlast) begin
            pkt_bytes      <= '0;
            last_pkt_bytes <= pkt_bytes + beat_bytes;
         end else begin
            pkt_bytes      <= pkt_bytes + beat_bytes;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_pack_32to128.sv
// Directed bench for axis_pack_32to128: reset, full and partial packets,
// single-beat packet, backpressure, back-to-back packets, mid-packet reset.
module tb_axis_pack_32to128;
   import axis_pack_32to128_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   axis_pack_32to128_if #(.W(32))  s_if ();
   axis_pack_32to128_if #(.W(128)) m_if ();
   pack_state_t dbg_state;
`ifdef AXIS_PACK_BYTE_CNT_EN
   logic [31:0] pkt_bytes, last_pkt_bytes;
`endif

   axis_pack_32to128 dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_axis    (s_if.slave),
      .m_axis    (m_if.master),
      .dbg_state (dbg_state)
`ifdef AXIS_PACK_BYTE_CNT_EN
      ,
      .pkt_bytes      (pkt_bytes),
      .last_pkt_bytes (last_pkt_bytes)
`endif
   );

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int cycle     = 0;

   logic [127:0] got_data_q[$];
   logic [15:0]  got_keep_q[$];
   logic         got_last_q[$];
   int           got_cyc_q[$];

   always @(posedge clk) cycle++;

   // Output monitor: record every word handed to the consumer.
   always @(negedge clk) begin
      if (resetn && m_if.tvalid && m_if.tready) begin
         got_data_q.push_back(m_if.tdata);
         got_keep_q.push_back(m_if.tkeep);
         got_last_q.push_back(m_if.tlast);
         got_cyc_q.push_back(cycle);
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and keep it until accepted; valid stays high on return.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      logic got;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         if (s_if.tready) got = 1'b1;
         n++;
      end
      check("send_accepted", {127'd0, got}, 128'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_input();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int k;
      k = 0;
      while (got_data_q.size() < n && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("word_count", 128'(got_data_q.size()), 128'(n));
   endtask

   task automatic check_word(input string tag, input logic [127:0] d, input logic [15:0] k,
                             input logic l);
      if (got_data_q.size() == 0) begin
         check({tag, "_present"}, 128'd0, 128'd1);
      end else begin
         check({tag, "_data"}, got_data_q.pop_front(), d);
         check({tag, "_keep"}, 128'(got_keep_q.pop_front()), 128'(k));
         check({tag, "_last"}, 128'(got_last_q.pop_front()), 128'(l));
         void'(got_cyc_q.pop_front());
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      check("rst_m_tvalid", 128'(m_if.tvalid), 128'd0);
      check("rst_m_tdata",  m_if.tdata, 128'd0);
      check("rst_m_tkeep",  128'(m_if.tkeep), 128'd0);
      check("rst_m_tlast",  128'(m_if.tlast), 128'd0);
      check("rst_s_tready", 128'(s_if.tready), 128'd0);
      check("rst_state",    128'(dbg_state), 128'(ST_IDLE));
`ifdef AXIS_PACK_BYTE_CNT_EN
      check("rst_last_pkt_bytes", 128'(last_pkt_bytes), 128'd0);
`endif
      @(posedge clk);
      #1;
      resetn = 1'b1;
      wait_cycles(2);
   endtask

   initial begin
      int c0, c1, c2, c3;
      logic [127:0] snap_d;
      logic [15:0]  snap_k;
      logic         snap_l, stable;
      int k;

      resetn      = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;

      // Reset state and release.
      do_reset();
      @(negedge clk);
      check("post_rst_s_tready", 128'(s_if.tready), 128'd1);
      @(posedge clk);
      #1;

      // Full 4-beat packet.
      send_beat(32'h11111111, 4'hF, 1'b0);
      send_beat(32'h22222222, 4'hF, 1'b0);
      send_beat(32'h33333333, 4'hF, 1'b0);
      send_beat(32'h44444444, 4'hF, 1'b1);
      idle_input();
      wait_words(1);
      check_word("full", 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1);

      // 6-beat packet: one full word, one half word.
      for (int i = 0; i < 6; i++) send_beat(32'hA000_0000 | 32'(i), 4'hF, i == 5);
      idle_input();
      wait_words(2);
      check_word("six_w0", 128'hA0000003_A0000002_A0000001_A0000000, 16'hFFFF, 1'b0);
      check_word("six_w1", 128'h00000000_00000000_A0000005_A0000004, 16'h00FF, 1'b1);
`ifdef AXIS_PACK_BYTE_CNT_EN
      check("six_last_pkt_bytes", 128'(last_pkt_bytes), 128'd24);
`endif

      // Single-beat packet with two valid bytes.
      send_beat(32'hDEADBEEF, 4'h3, 1'b1);
      idle_input();
      wait_words(1);
      check_word("single", 128'h00000000_00000000_00000000_DEADBEEF, 16'h0003, 1'b1);
`ifdef AXIS_PACK_BYTE_CNT_EN
      check("single_last_pkt_bytes", 128'(last_pkt_bytes), 128'd2);
      check("single_pkt_bytes", 128'(pkt_bytes), 128'd0);
`endif

      // Backpressure during a 12-beat stream.
      m_if.tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) send_beat(32'hC000_0000 | 32'(i), 4'hF, i == 11);
            idle_input();
         end
         begin
            k = 0;
            @(negedge clk);
            while (!m_if.tvalid && k < 50) begin
               @(negedge clk);
               k++;
            end
            check("bp_first_valid", 128'(m_if.tvalid), 128'd1);
            snap_d = m_if.tdata;
            snap_k = m_if.tkeep;
            snap_l = m_if.tlast;
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               if (m_if.tdata !== snap_d || m_if.tkeep !== snap_k || m_if.tlast !== snap_l ||
                   m_if.tvalid !== 1'b1 || s_if.tready !== 1'b0) stable = 1'b0;
            end
            check("bp_hold_stable", 128'(stable), 128'd1);
            check("bp_held_data", snap_d, 128'hC0000003_C0000002_C0000001_C0000000);
            @(posedge clk);
            #1;
            m_if.tready = 1'b1;
         end
      join
      wait_words(3);
      check_word("bp_w0", 128'hC0000003_C0000002_C0000001_C0000000, 16'hFFFF, 1'b0);
      check_word("bp_w1", 128'hC0000007_C0000006_C0000005_C0000004, 16'hFFFF, 1'b0);
      check_word("bp_w2", 128'hC000000B_C000000A_C0000009_C0000008, 16'hFFFF, 1'b1);

      // Two back-to-back 8-beat packets with continuous valid.
      for (int i = 0; i < 16; i++)
         send_beat(32'h5000_0000 | 32'(i), 4'hF, (i == 7) || (i == 15));
      idle_input();
      wait_words(4);
      if (got_cyc_q.size() >= 4) begin
         c0 = got_cyc_q[0];
         c1 = got_cyc_q[1];
         c2 = got_cyc_q[2];
         c3 = got_cyc_q[3];
         check("b2b_gap1", 128'(c1 - c0), 128'd4);
         check("b2b_gap2", 128'(c2 - c1), 128'd4);
         check("b2b_gap3", 128'(c3 - c2), 128'd4);
      end
      check_word("b2b_w0", 128'h50000003_50000002_50000001_50000000, 16'hFFFF, 1'b0);
      check_word("b2b_w1", 128'h50000007_50000006_50000005_50000004, 16'hFFFF, 1'b1);
      check_word("b2b_w2", 128'h5000000B_5000000A_50000009_50000008, 16'hFFFF, 1'b0);
      check_word("b2b_w3", 128'h5000000F_5000000E_5000000D_5000000C, 16'hFFFF, 1'b1);

      // Reset with a pending output word, then reset mid-packet.
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(32'hEEEE_0000 | 32'(i), 4'hF, 1'b0);
      idle_input();
      wait_cycles(2);
      check("pend_valid", 128'(m_if.tvalid), 128'd1);
      do_reset();
      m_if.tready = 1'b1;
      send_beat(32'hBAD00000, 4'hF, 1'b0);
      send_beat(32'hBAD00001, 4'hF, 1'b0);
      idle_input();
      wait_cycles(1);
      check("mid_state_fill", 128'(dbg_state), 128'(ST_FILL));
      do_reset();
      for (int i = 0; i < 4; i++) send_beat(32'h5555_0000 | 32'(i), 4'hF, i == 3);
      idle_input();
      wait_words(1);
      wait_cycles(5);
      check("post_rst_word_count", 128'(got_data_q.size()), 128'd1);
      check_word("post_rst", 128'h55550003_55550002_55550001_55550000, 16'hFFFF, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
